// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall detection and CPU/DMA bus
// arbitration with pipeline drain and a grant watchdog.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_GRANT    = 64,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_rd,
    input  logic        dma_req,
    output logic        pc_en,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        bubble_id_ex,
    output logic        dma_grant,
    output logic        dma_timeout,
    output logic [15:0] stall_cnt
);

    typedef enum logic [2:0] {
        RUN,
        LU_STALL,
        DMA_DRAIN,
        DMA_GRANT,
        DMA_WAIT_LOW
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0] grant_cnt;
    logic             lu;
    logic             drain_last;
    logic             grant_last;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Register 0 is hard-wired zero, so a load targeting it never hazards.
    assign lu = ex_mem_rd && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign drain_last = (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));
    assign grant_last = (grant_cnt == CNT_W'(MAX_GRANT - 1));

    always_comb begin
        state_nxt    = state;
        pc_en        = 1'b1;
        en_if_id     = 1'b1;
        en_id_ex     = 1'b1;
        bubble_id_ex = 1'b0;
        case (state)
            RUN: begin
                if (lu) begin
                    pc_en        = 1'b0;
                    en_if_id     = 1'b0;
                    bubble_id_ex = 1'b1;
                    state_nxt    = LU_STALL;
                end else if (dma_req) begin
                    state_nxt = DMA_DRAIN;
                end
            end
            LU_STALL: begin
                state_nxt = dma_req ? DMA_DRAIN : RUN;
            end
            DMA_DRAIN: begin
                pc_en        = 1'b0;
                en_if_id     = 1'b0;
                bubble_id_ex = 1'b1;
                if (!dma_req) begin
                    state_nxt = RUN;
                end else if (drain_last) begin
                    state_nxt = DMA_GRANT;
                end
            end
            DMA_GRANT: begin
                pc_en    = 1'b0;
                en_if_id = 1'b0;
                en_id_ex = 1'b0;
                if (!dma_req) begin
                    state_nxt = RUN;
                end else if (grant_last) begin
                    state_nxt = DMA_WAIT_LOW;
                end
            end
            DMA_WAIT_LOW: begin
                // Stall for load-use in place; the request must drop before re-arming.
                if (lu) begin
                    pc_en        = 1'b0;
                    en_if_id     = 1'b0;
                    bubble_id_ex = 1'b1;
                end
                if (!dma_req) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (!rst_n) begin
            pc_en        = 1'b0;
            en_if_id     = 1'b0;
            en_id_ex     = 1'b0;
            bubble_id_ex = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            grant_cnt   <= '0;
            dma_grant   <= 1'b0;
            dma_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= (state == DMA_DRAIN) ? drain_cnt + CNT_W'(1) : '0;
            grant_cnt   <= (state == DMA_GRANT) ? grant_cnt + CNT_W'(1) : '0;
            dma_grant   <= (state_nxt == DMA_GRANT);
            dma_timeout <= (state == DMA_GRANT) && dma_req && grant_last;
            if (!pc_en) begin
                stall_cnt <= sat_inc16(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int DRN  = 3;
    localparam int MAXG = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  ex_rd;
    logic        ex_mem_rd;
    logic        dma_req;
    logic        pc_en;
    logic        en_if_id;
    logic        en_id_ex;
    logic        bubble_id_ex;
    logic        dma_grant;
    logic        dma_timeout;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: remaining drain bubbles, grant age, one-shot stall flag,
    // ignore-request flag after a watchdog revocation.
    int m_drain_left;
    int m_grant_age;
    bit m_stall_once;
    bit m_ignore_req;
    bit m_timeout;
    int m_stall;

    int  first_grant;
    int  grant_cycles;
    int  timeout_cycles;
    int  regrants;
    logic r_req;

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES(DRN),
        .MAX_GRANT   (MAXG),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_rd       (ex_rd),
        .ex_mem_rd   (ex_mem_rd),
        .dma_req     (dma_req),
        .pc_en       (pc_en),
        .en_if_id    (en_if_id),
        .en_id_ex    (en_id_ex),
        .bubble_id_ex(bubble_id_ex),
        .dma_grant   (dma_grant),
        .dma_timeout (dma_timeout),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_drain_left = 0;
        m_grant_age  = -1;
        m_stall_once = 1'b0;
        m_ignore_req = 1'b0;
        m_timeout    = 1'b0;
        m_stall      = 0;
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic mrd, input logic req);
        bit lu_e;
        bit e_pc, e_ifid, e_idex, e_bub;
        bit t_next;
        @(negedge clk);
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = urt;
        ex_rd      = rd;
        ex_mem_rd  = mrd;
        dma_req    = req;
        #1;
        lu_e = mrd && (rd != 5'd0) && ((rd == rs) || (urt && (rd == rt)));
        {e_pc, e_ifid, e_idex, e_bub} = 4'b1110;
        if (m_grant_age >= 0)       {e_pc, e_ifid, e_idex, e_bub} = 4'b0000;
        else if (m_drain_left > 0)  {e_pc, e_ifid, e_idex, e_bub} = 4'b0011;
        else if (m_stall_once)      {e_pc, e_ifid, e_idex, e_bub} = 4'b1110;
        else if (lu_e)              {e_pc, e_ifid, e_idex, e_bub} = 4'b0011;
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("en_if_id", 32'(en_if_id), 32'(e_ifid));
        chk("en_id_ex", 32'(en_id_ex), 32'(e_idex));
        chk("bubble_id_ex", 32'(bubble_id_ex), 32'(e_bub));
        chk("dma_grant", 32'(dma_grant), 32'(m_grant_age >= 0));
        chk("dma_timeout", 32'(dma_timeout), 32'(m_timeout));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));

        t_next = 1'b0;
        if (m_grant_age >= 0) begin
            if (!req) m_grant_age = -1;
            else if (m_grant_age == MAXG - 1) begin
                m_grant_age  = -1;
                m_ignore_req = 1'b1;
                t_next       = 1'b1;
            end else m_grant_age++;
        end else if (m_drain_left > 0) begin
            if (!req) m_drain_left = 0;
            else if (m_drain_left == 1) begin
                m_drain_left = 0;
                m_grant_age  = 0;
            end else m_drain_left--;
        end else if (m_stall_once) begin
            m_stall_once = 1'b0;
            if (req) m_drain_left = DRN;
        end else if (m_ignore_req) begin
            if (!req) m_ignore_req = 1'b0;
        end else begin
            if (lu_e) m_stall_once = 1'b1;
            else if (req) m_drain_left = DRN;
        end
        if (!e_pc && m_stall < 65535) m_stall++;
        m_timeout = t_next;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        {id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_rd, dma_req} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_en_if_id", 32'(en_if_id), 0);
        chk("rst_en_id_ex", 32'(en_id_ex), 0);
        chk("rst_bubble", 32'(bubble_id_ex), 0);
        chk("rst_grant", 32'(dma_grant), 0);
        chk("rst_timeout", 32'(dma_timeout), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        idle(3);

        // Load-use on rs, then ex_rd=0 and unused rt must not stall
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        idle(1);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        step(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        step(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0);
        idle(1);
        chk("no_lu_stall_cnt", 32'(stall_cnt), 1);
        step(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
        idle(2);

        // DMA request held 10 cycles
        first_grant  = -1;
        grant_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, i < 10);
            if (dma_grant) begin
                grant_cycles++;
                if (first_grant < 0) first_grant = i;
            end
        end
        chk("dma_first_grant", 32'(first_grant), 4);
        chk("dma_grant_cycles", 32'(grant_cycles), 7);

        // Load-use and DMA request together
        first_grant = -1;
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        for (int i = 1; i < 9; i++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            if (dma_grant && first_grant < 0) first_grant = i;
        end
        chk("lu_dma_first_grant", 32'(first_grant), 5);
        idle(3);

        // Watchdog revocation
        grant_cycles   = 0;
        timeout_cycles = 0;
        regrants       = 0;
        for (int i = 0; i < 20; i++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            if (dma_grant) grant_cycles++;
            if (dma_timeout) timeout_cycles++;
            if (dma_grant && i >= 12) regrants++;
        end
        chk("wd_grant_cycles", 32'(grant_cycles), MAXG);
        chk("wd_timeout_pulses", 32'(timeout_cycles), 1);
        chk("wd_no_regrant", 32'(regrants), 0);
        chk("wd_pipe_runs", 32'(pc_en), 1);
        idle(1);
        first_grant = -1;
        for (int i = 0; i < 6; i++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            if (dma_grant && first_grant < 0) first_grant = i;
        end
        chk("wd_regrant_first", 32'(first_grant), 4);

        // Asynchronous reset while granted
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(dma_grant), 0);
        chk("arst_pc_en", 32'(pc_en), 0);
        chk("arst_en_id_ex", 32'(en_id_ex), 0);
        @(posedge clk);
        @(negedge clk);
        dma_req = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        #1;
        chk("arst_stall_cnt", 32'(stall_cnt), 0);
        idle(2);

        // Randomized traffic
        r_req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) r_req = ~r_req;
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), r_req);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF / IF_ID / ID / ID_EX / EX datapath.
- Generates the PC enable, the IF_ID enable, the ID_EX enable and the ID_EX bubble-insert signal.
- Detects load-use hazards between the ID and EX stages.
- Arbitrates the datapath and memory bus between the CPU pipeline and the DMA module: drains the pipeline, grants the bus, and enforces a grant watchdog.

Parameters:
- DRAIN_CYCLES, 3: bubble cycles inserted before a DMA grant so that EX/MEM/WB are empty.
- MAX_GRANT, 64: maximum consecutive dma_grant cycles before forced revocation.
- CNT_W, 8: width of the internal drain and grant counters; must satisfy 2^CNT_W > MAX_GRANT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  ID-stage source register A address
- id_rt  in  5  ID-stage source register B address
- id_uses_rt  in  1  ID instruction reads id_rt (0 for immediate forms)
- ex_rd  in  5  EX-stage destination register
- ex_mem_rd  in  1  EX-stage instruction is a load
- dma_req  in  1  DMA bus request, level, held until done
- pc_en  out  1  PC update enable
- en_if_id  out  1  IF_ID register enable
- en_id_ex  out  1  ID_EX register enable
- bubble_id_ex  out  1  load NOP (all-zero control) into ID_EX instead of ID data
- dma_grant  out  1  registered bus grant to DMA
- dma_timeout  out  1  registered one-cycle pulse on watchdog revocation
- stall_cnt  out  16  saturating count of stall cycles (load-use plus DMA), for debug

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; counters=0; dma_grant=0; dma_timeout=0; stall_cnt=0.
  - While rst_n=0, pc_en, en_if_id, en_id_ex and bubble_id_ex are all forced 0.
- Hazard term: lu = ex_mem_rd & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)). Register 0 never hazards.
- States: RUN, LU_STALL, DMA_DRAIN, DMA_GRANT, DMA_WAIT_LOW. Outputs are combinational from state and lu (Mealy); dma_grant and dma_timeout are registered.
- RUN:
  - lu=0: pc_en=en_if_id=en_id_ex=1, bubble=0.
  - lu=1: pc_en=en_if_id=0, en_id_ex=1, bubble=1; next state LU_STALL.
  - lu=0 & dma_req=1: normal advance this cycle, next state DMA_DRAIN, drain counter=0.
  - lu=1 & dma_req=1: load-use wins; go to LU_STALL. dma_req is re-evaluated there.
- LU_STALL (exactly 1 cycle):
  - Outputs as in RUN with lu=0; the load has moved on, so no re-check.
  - Next state: DMA_DRAIN if dma_req=1, else RUN.
- DMA_DRAIN:
  - pc_en=en_if_id=0, en_id_ex=1, bubble=1. The counter increments each cycle.
  - When counter==DRAIN_CYCLES-1, next state DMA_GRANT; dma_grant rises at that edge.
  - If dma_req drops during drain, return to RUN next cycle with no grant.
- DMA_GRANT:
  - All enables 0, bubble=0, dma_grant=1. The grant counter increments each cycle.
  - dma_req=0: dma_grant clears at the next edge; next state RUN.
  - Grant counter==MAX_GRANT-1 with dma_req still 1: next edge clears dma_grant, pulses dma_timeout for 1 cycle, next state DMA_WAIT_LOW.
- DMA_WAIT_LOW:
  - Pipeline runs as in RUN, including lu handling without a state change; dma_req is ignored.
  - dma_req=0: next state RUN.
- stall_cnt: +1 on every cycle with pc_en=0 outside reset; saturates at 0xFFFF.
- Reset mid-DMA: dma_grant drops immediately (asynchronously); state returns to RUN.
- Latency: dma_req in RUN to dma_grant=1 is DRAIN_CYCLES+1 edges (default 4). Grant release is 1 edge after dma_req falls.

Test Plan:
- Reset release, then idle inputs (lu=0, dma_req=0) -> pc_en=en_if_id=en_id_ex=1, bubble=0, dma_grant=0, stall_cnt=0.
- Load-use: ex_mem_rd=1, ex_rd=5, id_rs=5 -> one cycle with pc_en=0, bubble=1, then RUN; stall_cnt=1. Repeat with ex_rd=0 -> no stall. Repeat with id_rt=5, id_uses_rt=0 -> no stall.
- DMA request from RUN, held 10 cycles then dropped -> 3 bubble cycles, dma_grant=1 at edge 4, all enables 0 while granted, grant 0 one edge after dma_req falls, pipeline resumes.
- Load-use and dma_req asserted in the same cycle -> 1 LU_STALL cycle, then 3 drain cycles, then grant (5 edges total).
- Watchdog: MAX_GRANT=8, dma_req held indefinitely -> grant high exactly 8 cycles, dma_timeout pulse of 1 cycle, pipeline runs, no regrant until dma_req goes low and high again.
- rst_n pulled low during DMA_GRANT -> dma_grant=0 without waiting for a clock edge; after release, RUN with counters cleared.
